// File: rtl/onehot_demux.sv
`default_nettype none
// ============================================================================
// Module      : onehot_demux
// Description : Registered one-hot demultiplexer. Routes one WIDTH-bit word
//               per valid/ready transfer into a single-entry holding register
//               on the channel chosen by a one-hot select. Each channel
//               drains through its own valid/ready handshake. Selects that
//               are not one-hot are dropped, counted and flagged.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               in_data/in_sel/in_valid  producer side, in_ready back-pressure
//               out_data/out_valid       per-channel words (flattened data)
//               out_ready                per-channel consumer accept
//               err_clr                  clears sel_err and drop_count
//               sel_err/drop_count       sticky error flag, saturating count
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_demux #(
    parameter int WIDTH = 4,
    parameter int N     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [N-1:0]       in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    input  logic               err_clr,
    output logic               sel_err,
    output logic [7:0]         drop_count
);

    localparam int c_CNT_W = $clog2(N + 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    logic [c_CNT_W-1:0] w_sel_count;
    logic               w_legal;
    logic [N-1:0]       w_writable;
    logic               w_target_writable;
    logic               w_accept;
    logic [N-1:0]       w_load;

    logic               r_sel_err;
    logic [7:0]         r_drop_count;

    // Population count of the select; legal means exactly one bit set.
    always_comb begin
        w_sel_count = '0;
        for (int i = 0; i < N; i++) begin
            w_sel_count = w_sel_count + c_CNT_W'(in_sel[i]);
        end
    end

    assign w_legal = (w_sel_count == c_CNT_W'(1));

    // With a legal select only one bit of in_sel is set, so the OR-reduce
    // picks out the writable flag of the target channel alone.
    assign w_target_writable = |(in_sel & w_writable);

    // Illegal selects are always accepted so the producer never stalls on a
    // transfer that is going to be discarded anyway.
    assign in_ready = w_legal ? w_target_writable : 1'b1;
    assign w_accept = in_valid & in_ready;
    assign w_load   = (w_accept && w_legal) ? in_sel : '0;

    generate
        for (genvar k = 0; k < N; k++) begin : g_chan
            state_t             r_state;
            state_t             w_state_next;
            logic [WIDTH-1:0]   r_data;

            // Pass-through reload: a FULL channel whose consumer takes the
            // word this cycle can accept a new one in the same cycle.
            assign w_writable[k] = (r_state == ST_EMPTY) || out_ready[k];

            always_comb begin
                w_state_next = r_state;
                if (w_load[k]) begin
                    w_state_next = ST_FULL;
                end else if ((r_state == ST_FULL) && out_ready[k]) begin
                    w_state_next = ST_EMPTY;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= ST_EMPTY;
                    r_data  <= '0;
                end else begin
                    r_state <= w_state_next;
                    if (w_load[k]) begin
                        r_data <= in_data;
                    end
                end
            end

            assign out_valid[k]                  = (r_state == ST_FULL);
            assign out_data[k*WIDTH +: WIDTH]    = r_data;
        end
    endgenerate

    // Error bookkeeping; err_clr takes priority over a coincident drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_err    <= 1'b0;
            r_drop_count <= '0;
        end else if (err_clr) begin
            r_sel_err    <= 1'b0;
            r_drop_count <= '0;
        end else if (w_accept && !w_legal) begin
            r_sel_err <= 1'b1;
            if (r_drop_count != 8'hFF) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign sel_err    = r_sel_err;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_onehot_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_demux
// Description : Self-checking bench for onehot_demux. A behavioural model of
//               the channels (arrays of valid flags and words) is compared
//               against the DUT every cycle, and directed scenarios also pin
//               hand-computed literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_demux;

    localparam int WIDTH = 4;
    localparam int N     = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic [WIDTH-1:0]   in_data;
    logic [N-1:0]       in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ready;
    logic               err_clr;
    logic               sel_err;
    logic [7:0]         drop_count;

    onehot_demux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_clr    (err_clr),
        .sel_err    (sel_err),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_valid [N];
    int       m_data  [N];
    bit       m_err  = 1'b0;
    int       m_cnt  = 0;

    function automatic bit m_legal();
        return $countones(in_sel) == 1;
    endfunction

    function automatic int m_target();
        for (int i = 0; i < N; i++) if (in_sel[i]) return i;
        return 0;
    endfunction

    function automatic bit m_ready();
        if (!m_legal()) return 1'b1;
        return !m_valid[m_target()] || out_ready[m_target()];
    endfunction

    always @(posedge clk) begin
        bit acc;
        acc = in_valid && m_ready();
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] = 1'b0;
                m_data[i]  = 0;
            end
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            for (int i = 0; i < N; i++) if (m_valid[i] && out_ready[i]) m_valid[i] = 1'b0;
            if (acc && m_legal()) begin
                m_valid[m_target()] = 1'b1;
                m_data[m_target()]  = int'(in_data);
            end
            if (err_clr) begin
                m_err = 1'b0;
                m_cnt = 0;
            end else if (acc && !m_legal()) begin
                m_err = 1'b1;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0]       ev;
            logic [N*WIDTH-1:0] ed;
            for (int i = 0; i < N; i++) begin
                ev[i] = m_valid[i];
                ed[i*WIDTH +: WIDTH] = m_data[i][WIDTH-1:0];
            end
            check("model out_valid", 32'(out_valid), 32'(ev));
            check("model out_data", 32'(out_data), 32'(ed));
            check("model in_ready", 32'(in_ready), 32'(m_ready()));
            check("model sel_err", 32'(sel_err), 32'(m_err));
            check("model drop_count", 32'(drop_count), 32'(m_cnt));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Mixed traffic table: {sel, data, out_ready, valid}
    logic [N-1:0]     t_sel  [8] = '{6'b001000, 6'b001000, 6'b001000, 6'b100000,
                                     6'b100000, 6'b000011, 6'b010000, 6'b001000};
    logic [WIDTH-1:0] t_data [8] = '{4'h1, 4'h2, 4'h3, 4'h9, 4'hC, 4'hF, 4'h6, 4'hE};
    logic [N-1:0]     t_rdy  [8] = '{6'b001000, 6'b001000, 6'b001000, 6'b000000,
                                     6'b000000, 6'b000000, 6'b100000, 6'b000000};

    initial begin
        rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0;
        out_ready = '0; err_clr = 1'b0;
        cyc();
        chk_en = 1'b1;
        at_neg();
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset out_data", 32'(out_data), 32'h0);
        check("reset in_ready", 32'(in_ready), 32'h1);
        check("reset drop_count", 32'(drop_count), 32'h0);
        rst = 1'b0;
        cyc();

        // Load channel 2, then back-pressure it while channel 0 proceeds.
        in_sel = 6'b000100; in_data = 4'hA; in_valid = 1'b1;
        cyc();
        in_data = 4'h5;
        at_neg();
        check("ch2 out_valid", 32'(out_valid), 32'h04);
        check("ch2 data A", 32'(out_data[11:8]), 32'hA);
        check("ch2 blocked ready", 32'(in_ready), 32'h0);
        in_sel = 6'b000001; in_data = 4'h7;
        #1;
        check("ch0 ready", 32'(in_ready), 32'h1);
        cyc();
        in_valid = 1'b0;
        at_neg();
        check("ch0+ch2 valid", 32'(out_valid), 32'h05);
        check("ch0 data", 32'(out_data[3:0]), 32'h7);

        // Pass-through reload of channel 2.
        in_sel = 6'b000100; in_data = 4'h3; in_valid = 1'b1; out_ready = 6'b000100;
        #1;
        check("reload ready", 32'(in_ready), 32'h1);
        cyc();
        in_valid = 1'b0; out_ready = '0;
        at_neg();
        check("reload valid2", 32'(out_valid[2]), 32'h1);
        check("reload data", 32'(out_data[11:8]), 32'h3);
        out_ready = 6'b111111;
        cyc();
        out_ready = '0;

        // Two illegal selects, then clear.
        in_sel = 6'b000000; in_valid = 1'b1;
        at_neg();
        check("zero sel ready", 32'(in_ready), 32'h1);
        cyc();
        in_sel = 6'b010010;
        at_neg();
        check("multi sel ready", 32'(in_ready), 32'h1);
        cyc();
        in_valid = 1'b0;
        at_neg();
        check("illegal valid", 32'(out_valid), 32'h0);
        check("illegal sel_err", 32'(sel_err), 32'h1);
        check("illegal count", 32'(drop_count), 32'h2);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        at_neg();
        check("clr sel_err", 32'(sel_err), 32'h0);
        check("clr count", 32'(drop_count), 32'h0);

        // Saturation, then clear coinciding with an illegal accept.
        in_sel = 6'b000000; in_valid = 1'b1;
        for (int i = 0; i < 260; i++) cyc();
        in_valid = 1'b0;
        at_neg();
        check("sat count", 32'(drop_count), 32'd255);
        check("sat sel_err", 32'(sel_err), 32'h1);
        in_sel = 6'b110000; in_valid = 1'b1; err_clr = 1'b1;
        cyc();
        in_valid = 1'b0; err_clr = 1'b0;
        at_neg();
        check("clr wins count", 32'(drop_count), 32'h0);
        check("clr wins err", 32'(sel_err), 32'h0);

        // Mixed traffic table including single-channel streaming.
        for (int i = 0; i < 8; i++) begin
            in_sel = t_sel[i]; in_data = t_data[i]; out_ready = t_rdy[i]; in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0; out_ready = 6'b111111;
        cyc();
        out_ready = '0;

        // Fill all channels with 0..5, drain together.
        for (int k = 0; k < N; k++) begin
            in_sel = N'(1 << k); in_data = WIDTH'(k); in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        at_neg();
        check("fill valid", 32'(out_valid), 32'h3F);
        check("fill data", 32'(out_data), 32'h543210);
        out_ready = 6'b111111;
        cyc();
        out_ready = '0;
        at_neg();
        check("drain valid", 32'(out_valid), 32'h0);

        // Refill, then reset with channels full.
        for (int k = 0; k < N; k++) begin
            in_sel = N'(1 << k); in_data = WIDTH'(k + 8); in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        at_neg();
        check("rst valid", 32'(out_valid), 32'h0);
        check("rst data", 32'(out_data), 32'h0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
